// File: rtl/div_request_queue_if.sv
// Request, divider and result handshakes of the divider request queue.
// The slave modport is the queue's view; master is the surrounding system's view.
interface div_request_queue_if #(
  parameter int WIDTH = 13
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;

  logic             div_start;
  logic             div_sign;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_ready;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div0;
  logic             out_err;

  modport slave (
    input  in_valid, in_sign, in_dividend, in_divisor,
    output in_ready,
    output div_start, div_sign, div_dividend, div_divisor,
    input  div_quotient, div_remainder, div_ready,
    output out_valid, out_quotient, out_remainder, out_div0, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_sign, in_dividend, in_divisor,
    input  in_ready,
    input  div_start, div_sign, div_dividend, div_divisor,
    output div_quotient, div_remainder, div_ready,
    input  out_valid, out_quotient, out_remainder, out_div0, out_err,
    output out_ready
  );
endinterface

// File: rtl/div_request_queue.sv
// Buffers division requests, issues them one at a time to a sequential divider,
// bypasses divide-by-zero and aborts on a hung divider; results leave in order.
module div_request_queue #(
  parameter int WIDTH   = 13,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  div_request_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_TICK  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, OUTPUT} state_t;

  state_t state, state_next;

  logic             mem_sign     [DEPTH];
  logic [WIDTH-1:0] mem_dividend [DEPTH];
  logic [WIDTH-1:0] mem_divisor  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [CW-1:0]    timer;

  logic full, empty, push, head_div0, timed_out;
  logic pop, issue, load_div0, load_done, load_err, ack;

  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign bus.in_ready = !full && !reset;
  assign push         = bus.in_valid && bus.in_ready;
  assign head_div0    = (mem_divisor[rd_ptr] == '0);
  assign timed_out    = (timer == LAST_TICK);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_sign[wr_ptr]     <= bus.in_sign;
      mem_dividend[wr_ptr] <= bus.in_dividend;
      mem_divisor[wr_ptr]  <= bus.in_divisor;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Completion is only accepted after the divider has been seen busy, so a
  // stale div_ready from the previous operation never ends the wait.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!empty) state_next = head_div0 ? OUTPUT : WAIT_BUSY;
      WAIT_BUSY: if (timed_out) state_next = OUTPUT;
                 else if (!bus.div_ready) state_next = WAIT_DONE;
      WAIT_DONE: if (bus.div_ready || timed_out) state_next = OUTPUT;
      OUTPUT:    if (bus.out_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    issue     = 1'b0;
    load_div0 = 1'b0;
    load_done = 1'b0;
    load_err  = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        issue     = !head_div0;
        load_div0 = head_div0;
      end
      WAIT_BUSY: load_err = timed_out;
      WAIT_DONE: begin
        load_done = bus.div_ready;
        load_err  = !bus.div_ready && timed_out;
      end
      OUTPUT:  ack = bus.out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      timer             <= '0;
      bus.div_start     <= 1'b0;
      bus.div_sign      <= 1'b0;
      bus.div_dividend  <= '0;
      bus.div_divisor   <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_quotient  <= '0;
      bus.out_remainder <= '0;
      bus.out_div0      <= 1'b0;
      bus.out_err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (issue) timer <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE) timer <= timer + 1'b1;

      bus.div_start <= issue;
      if (issue) begin
        bus.div_sign     <= mem_sign[rd_ptr];
        bus.div_dividend <= mem_dividend[rd_ptr];
        bus.div_divisor  <= mem_divisor[rd_ptr];
      end

      if (load_div0) begin
        bus.out_valid     <= 1'b1;
        bus.out_quotient  <= '1;
        bus.out_remainder <= mem_dividend[rd_ptr];
        bus.out_div0      <= 1'b1;
        bus.out_err       <= 1'b0;
      end else if (load_done) begin
        bus.out_valid     <= 1'b1;
        bus.out_quotient  <= bus.div_quotient;
        bus.out_remainder <= bus.div_remainder;
        bus.out_div0      <= 1'b0;
        bus.out_err       <= 1'b0;
      end else if (load_err) begin
        bus.out_valid     <= 1'b1;
        bus.out_quotient  <= '0;
        bus.out_remainder <= '0;
        bus.out_div0      <= 1'b0;
        bus.out_err       <= 1'b1;
      end else if (ack) begin
        bus.out_valid     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_div_request_queue.sv
// Directed bench for div_request_queue with a behavioural 14-cycle divider.
module tb_div_request_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_request_queue_if #(.WIDTH(13)) bus ();

  div_request_queue #(.WIDTH(13), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Divider model: drops div_ready the cycle after div_start, raises it with
  // the result LAT cycles later unless told to hang for one operation.
  int          lat = 14;
  bit          hang_once = 1'b0;
  bit          stab_on = 1'b1;
  bit          stab_err = 1'b0;
  int          start_cnt = 0;
  logic [12:0] ma, mb;
  logic        ms;

  always @(negedge clk) if (bus.div_start === 1'b1) start_cnt++;

  initial begin
    bus.div_ready     = 1'b1;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.div_start === 1'b1) begin
        ma = bus.div_dividend;
        mb = bus.div_divisor;
        ms = bus.div_sign;
        bus.div_ready = 1'b0;
        if (hang_once) hang_once = 1'b0;
        else begin
          repeat (lat) begin
            @(posedge clk); #1;
            if (stab_on && (bus.div_dividend !== ma || bus.div_divisor !== mb || bus.div_sign !== ms))
              stab_err = 1'b1;
          end
          bus.div_quotient  = ma / mb;
          bus.div_remainder = ma % mb;
          bus.div_ready     = 1'b1;
        end
      end
    end
  end

  task automatic push(input int dvd, input int dvs);
    bit ok = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_sign     = 1'b0;
    bus.in_dividend = 13'(dvd);
    bus.in_divisor  = 13'(dvs);
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("push_wait", 0, 1);
  endtask

  task automatic get(output logic [12:0] q, output logic [12:0] r, output logic d0, output logic er);
    bit seen = 1'b0;
    q = 'x; r = 'x; d0 = 1'bx; er = 1'bx;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        q = bus.out_quotient; r = bus.out_remainder;
        d0 = bus.out_div0; er = bus.out_err;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    if (!seen) check("result_wait", 0, 1);
  endtask

  logic [12:0] q, r;
  logic        d0, er;
  int          s0, acc, k, vcount;
  bit          seen, rdy5;
  int          exp_q[6] = '{3, 6, 10, 13, 16, 20};
  int          exp_r[6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    bus.in_valid = 1'b0; bus.in_sign = 1'b0;
    bus.in_dividend = '0; bus.in_divisor = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_div_start", bus.div_start, 0);
    check("rst_out_quotient", bus.out_quotient, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Single request: start pulse timing relative to acceptance edge E0.
    s0 = start_cnt;
    bus.in_valid = 1'b1; bus.in_dividend = 13'd1404; bus.in_divisor = 13'd5;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk); check("t1_start_e0", bus.div_start, 0);
    @(negedge clk); check("t1_start_e1", bus.div_start, 1);
    check("t1_div_dividend", bus.div_dividend, 1404);
    check("t1_div_divisor", bus.div_divisor, 5);
    @(negedge clk); check("t1_start_e2", bus.div_start, 0);
    @(posedge clk); #1;
    get(q, r, d0, er);
    check("t1_q", q, 280); check("t1_r", r, 4);
    check("t1_div0", d0, 0); check("t1_err", er, 0);
    check("t1_start_count", start_cnt - s0, 1);

    // Small over large.
    push(5, 1404);
    get(q, r, d0, er);
    check("t2_q", q, 0); check("t2_r", r, 5);
    check("t2_operands_stable", stab_err, 0);

    // Divide-by-zero bypass.
    s0 = start_cnt;
    bus.in_valid = 1'b1; bus.in_dividend = 13'd100; bus.in_divisor = 13'd0;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk); check("t3_valid_e0", bus.out_valid, 0);
    @(negedge clk); check("t3_valid_e1", bus.out_valid, 1);
    @(posedge clk); #1;
    get(q, r, d0, er);
    check("t3_q", q, 8191); check("t3_r", r, 100);
    check("t3_div0", d0, 1); check("t3_err", er, 0);
    check("t3_no_start", start_cnt - s0, 0);

    // Back-pressure: five accepted (one in flight + four queued), sixth held.
    acc = 0; rdy5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_dividend = 13'((i + 1) * 10); bus.in_divisor = 13'd3;
      @(negedge clk);
      if (bus.in_ready === 1'b1) acc++;
      if (i == 5) rdy5 = bus.in_ready;
      @(posedge clk); #1;
    end
    check("t4_accepted", acc, 5);
    check("t4_full_holdoff", rdy5, 0);
    fork
      push(60, 3);
      for (int j = 0; j < 6; j++) begin
        get(q, r, d0, er);
        check($sformatf("t4_q%0d", j), q, exp_q[j]);
        check($sformatf("t4_r%0d", j), r, exp_r[j]);
      end
    join
    check("t4_operands_stable", stab_err, 0);

    // Timeout, then the next queued request completes normally.
    hang_once = 1'b1;
    bus.in_valid = 1'b1; bus.in_dividend = 13'd77; bus.in_divisor = 13'd7;
    @(posedge clk); #1;
    bus.in_dividend = 13'd9; bus.in_divisor = 13'd2;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    k = 1; seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk); k++;
      seen = (bus.out_valid === 1'b1);
      if (!seen) begin @(posedge clk); #1; end
    end
    check("t5_timeout_cycle", k, 66);
    @(posedge clk); #1;
    get(q, r, d0, er);
    check("t5_q", q, 0); check("t5_r", r, 0);
    check("t5_err", er, 1); check("t5_div0", d0, 0);
    get(q, r, d0, er);
    check("t5_next_q", q, 4); check("t5_next_r", r, 1); check("t5_next_err", er, 0);

    // Reset while waiting on the divider with two requests queued.
    stab_on = 1'b0;
    s0 = start_cnt;
    bus.in_valid = 1'b1; bus.in_dividend = 13'd100; bus.in_divisor = 13'd7;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    push(200, 7);
    push(300, 7);
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_in_ready", bus.in_ready, 0);
    check("t6_div_start", bus.div_start, 0);
    check("t6_div_dividend", bus.div_dividend, 0);
    check("t6_div_divisor", bus.div_divisor, 0);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_out_quotient", bus.out_quotient, 0);
    check("t6_out_remainder", bus.out_remainder, 0);
    check("t6_out_err", bus.out_err, 0);
    reset = 1'b0;
    @(negedge clk); check("t6_in_ready_after", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    vcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) vcount++;
    end
    bus.out_ready = 1'b0;
    check("t6_no_late_result", vcount, 0);
    check("t6_start_count", start_cnt - s0, 1);
    @(posedge clk); #1;

    // Full-scale dividend after reset recovery.
    stab_on = 1'b1;
    push(8191, 13);
    get(q, r, d0, er);
    check("t7_q", q, 630); check("t7_r", r, 1);
    check("t7_err", er, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
